// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the shared memory and mem_arbiter.
// slave: arbiter side; master: requesters plus memory side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              f_req_i;
    logic [ADDR_W-1:0] f_addr_i;
    logic              f_flush_i;
    logic              f_gnt_o;
    logic              f_rvalid_o;
    logic [DATA_W-1:0] f_rdata_o;
    logic              d_req_i;
    logic              d_we_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic [3:0]        d_be_i;
    logic              d_gnt_o;
    logic              d_rvalid_o;
    logic [DATA_W-1:0] d_rdata_o;
    logic              m_en_o;
    logic              m_we_o;
    logic [ADDR_W-1:0] m_addr_o;
    logic [DATA_W-1:0] m_wdata_o;
    logic [3:0]        m_be_o;
    logic [DATA_W-1:0] m_rdata_i;
    logic              busy_o;
    logic              owner_o;

    modport slave (
        input  f_req_i, f_addr_i, f_flush_i,
        input  d_req_i, d_we_i, d_addr_i,
        input  d_wdata_i, d_be_i, m_rdata_i,
        output f_gnt_o, f_rvalid_o, f_rdata_o,
        output d_gnt_o, d_rvalid_o, d_rdata_o,
        output m_en_o, m_we_o, m_addr_o,
        output m_wdata_o, m_be_o,
        output busy_o, owner_o
    );

    modport master (
        output f_req_i, f_addr_i, f_flush_i,
        output d_req_i, d_we_i, d_addr_i,
        output d_wdata_i, d_be_i, m_rdata_i,
        input  f_gnt_o, f_rvalid_o, f_rdata_o,
        input  d_gnt_o, d_rvalid_o, d_rdata_o,
        input  m_en_o, m_we_o, m_addr_o,
        input  m_wdata_o, m_be_o,
        input  busy_o, owner_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates fetch (F, read-only) and data (D, read/write) ports onto one
// fixed-latency single-port memory: IDLE -> ISSUE -> WAIT -> RESP.
// Ports: clk_i, reset_i (async, active-low), bus (mem_arbiter_if.slave).
// Optional: MEM_ARB_STARVE_GUARD_EN bounds consecutive D grants while F waits.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
`ifdef MEM_ARB_STARVE_GUARD_EN
    , parameter int STARVE_MAX = 4
`endif
) (
    input  logic         clk_i,
    input  logic         reset_i,
    mem_arbiter_if.slave bus
);
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_RESP
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_cnt;
    logic              r_owner;
    logic              r_we;
    logic              r_sq;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [3:0]        r_be;
    logic [DATA_W-1:0] r_frdata;
    logic [DATA_W-1:0] r_drdata;
    logic              w_arb;
    logic              w_pick_d;
    logic              w_last;
    logic              w_fbusy;

    assign w_arb = ((r_state == S_IDLE) || (r_state == S_RESP))
                && (bus.f_req_i || bus.d_req_i);
    assign w_last = (r_state == S_WAIT)
                 && (r_cnt == CW'(MEM_LAT - 1));
    assign w_fbusy = (r_state != S_IDLE) && !r_owner;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 2);

    logic [SW-1:0] r_starve;
    logic          w_force_f;

    assign w_force_f = bus.f_req_i
                    && (r_starve == SW'(STARVE_MAX));
    assign w_pick_d = bus.d_req_i && !w_force_f;

    // Counts D grants issued while F was left waiting.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_starve <= '0;
        end else if (r_state == S_ISSUE && !r_owner) begin
            r_starve <= '0;
        end else if (r_state == S_ISSUE && bus.f_req_i) begin
            r_starve <= r_starve + 1'b1;
        end else if (w_arb && !bus.f_req_i) begin
            r_starve <= '0;
        end
    end
`else
    assign w_pick_d = bus.d_req_i;
`endif

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_arb) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (w_last) w_next = S_RESP;
            S_RESP:  w_next = w_arb ? S_ISSUE : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_cnt    <= '0;
            r_owner  <= 1'b0;
            r_we     <= 1'b0;
            r_sq     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_be     <= '0;
            r_frdata <= '0;
            r_drdata <= '0;
        end else begin
            if (w_arb) begin
                r_owner <= w_pick_d;
                r_addr  <= w_pick_d ? bus.d_addr_i
                                    : bus.f_addr_i;
                r_we    <= w_pick_d && bus.d_we_i;
                r_wdata <= w_pick_d ? bus.d_wdata_i : '0;
                r_be    <= (w_pick_d && bus.d_we_i)
                         ? bus.d_be_i : 4'b0000;
            end
            if (r_state == S_ISSUE) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // Clear wins: a flush in RESP belongs to the old access.
            if (w_arb) begin
                r_sq <= 1'b0;
            end else if (w_fbusy && bus.f_flush_i) begin
                r_sq <= 1'b1;
            end
            // A flush in the last WAIT cycle must already block capture.
            if (w_last && !r_owner
                && !(r_sq || bus.f_flush_i)) begin
                r_frdata <= bus.m_rdata_i;
            end
            if (w_last && r_owner && !r_we) begin
                r_drdata <= bus.m_rdata_i;
            end
        end
    end

    always_comb begin
        bus.m_en_o     = 1'b0;
        bus.m_we_o     = 1'b0;
        bus.m_be_o     = 4'b0000;
        bus.f_gnt_o    = 1'b0;
        bus.d_gnt_o    = 1'b0;
        bus.f_rvalid_o = 1'b0;
        bus.d_rvalid_o = 1'b0;
        bus.m_addr_o   = r_addr;
        bus.m_wdata_o  = r_wdata;
        bus.f_rdata_o  = r_frdata;
        bus.d_rdata_o  = r_drdata;
        bus.busy_o     = (r_state != S_IDLE);
        bus.owner_o    = r_owner;
        unique case (r_state)
            S_ISSUE: begin
                bus.m_en_o  = 1'b1;
                bus.m_we_o  = r_we;
                bus.m_be_o  = r_be;
                bus.f_gnt_o = !r_owner;
                bus.d_gnt_o = r_owner;
            end
            S_RESP: begin
                bus.f_rvalid_o = !r_owner && !r_sq;
                bus.d_rvalid_o = r_owner;
            end
            default: begin
            end
        endcase
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port unified memory between the fetch stage (read-only instruction port F) and the mem stage (read/write data port D) of the 5-stage pipeline. Arbitrates one access at a time and sequences the fixed-latency memory through issue, wait and response phases. Returns read data or write completion to the winning requester. Fetch responses can be squashed by a branch flush without disturbing the memory transaction.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 1, cycles from `m_en_o` to valid `m_rdata_i` (≥1)
- STARVE_MAX, 4, consecutive D grants allowed while F waits (guard build only)

- clk_i  in  1  clock, rising edge
- reset_i  in  1  asynchronous, active-low reset
- f_req_i  in  1  fetch read request, held until `f_gnt_o`
- f_addr_i  in  ADDR_W  fetch address
- f_flush_i  in  1  squash in-flight fetch response
- f_gnt_o  out  1  one-cycle grant pulse, request sampled
- f_rvalid_o  out  1  one-cycle read-data pulse
- f_rdata_o  out  DATA_W  fetch read data, held until next F response
- d_req_i  in  1  data request, held until `d_gnt_o`
- d_we_i  in  1  1 = write
- d_addr_i  in  ADDR_W  data address
- d_wdata_i  in  DATA_W  write data
- d_be_i  in  4  byte enables for writes
- d_gnt_o  out  1  one-cycle grant pulse
- d_rvalid_o  out  1  one-cycle completion pulse, reads and writes
- d_rdata_o  out  DATA_W  data read result, held until next D read response
- m_en_o, m_we_o  out  1  memory strobe / write enable
- m_addr_o  out  ADDR_W; m_wdata_o  out  DATA_W; m_be_o  out  4
- m_rdata_i  in  DATA_W  memory read data
- busy_o  out  1  state ≠ IDLE
- owner_o  out  1  0 = F, 1 = D, owner of current or last access

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE or RESP with any request pending: choose a winner, latch its address, data, we and be, then go to ISSUE. With no request pending, RESP goes to IDLE.
- Winner selection: D has priority over F (older instruction).
- ISSUE, one cycle:
  - `m_en_o`=1; `m_we_o`, addr, wdata and be driven from the latched values.
  - Winner's `gnt_o`=1; the requester may change or drop its request from the next cycle.
  - F is never written: `m_we_o`=0, `m_be_o`=0.
- WAIT: latency counter runs MEM_LAT cycles. In the last WAIT cycle, `m_rdata_i` is captured into the winner's rdata register (reads only). Go to RESP.
- RESP, one cycle: winner's `rvalid_o`=1. The F pulse is suppressed if squashed.
- Squash:
  - `f_flush_i` high in any cycle of an F access (ISSUE, WAIT or RESP) sets a squash flag.
  - With the flag set, `f_rvalid_o` stays 0 and `f_rdata_o` is not updated.
  - The flag clears on entry to the next ISSUE.
  - The memory access still completes.
  - `f_flush_i` with no F access in flight has no effect.
- D writes: `d_rvalid_o` pulses in RESP; `d_rdata_o` is unchanged.
- Simultaneous F and D requests: D wins (subject to the guard below). F keeps requesting and is re-arbitrated in RESP.
- Reset asserted mid-access: all state and outputs clear immediately (async). The memory transaction is abandoned and no response is produced.

## Timing
- All outputs reset to 0; state = IDLE, counters = 0.
- All outputs are registered; no combinational path from request to memory.
- Request seen in cycle 0 (IDLE):
  - Cycle 1: `m_en_o` and `gnt_o`.
  - Cycles 2 to 1+MEM_LAT: WAIT.
  - Cycle 2+MEM_LAT: `rvalid_o`.
- Back-to-back requests: the next ISSUE is in cycle 3+MEM_LAT, so each access occupies MEM_LAT+2 cycles.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined:
  - A counter increments on each D grant issued while `f_req_i`=1.
  - When the counter equals STARVE_MAX and `f_req_i`=1, the next arbitration grants F even if D requests.
  - The counter clears on any F grant and on any arbitration where `f_req_i`=0.
- Not defined: strict D priority, no counter logic. F can starve indefinitely.

## Test plan
- F read, MEM_LAT=1, addr 0x10, memory returns 0xE3A01005:
  - `f_gnt_o` in cycle 1, `m_addr_o`=0x10.
  - `f_rvalid_o` in cycle 3 with `f_rdata_o`=0xE3A01005.
- Simultaneous F req 0x20 and D read 0x100:
  - D is granted first: `d_rvalid_o` in cycle 3.
  - F `m_en_o` in cycle 4, `f_rvalid_o` in cycle 6.
- D write 0xDEADBEEF to 0x40 with be=4'b0011:
  - `m_we_o`=1, `m_be_o`=0011 in the issue cycle.
  - `d_rvalid_o` pulses; `d_rdata_o` is unchanged.
- `f_flush_i` pulsed during F WAIT:
  - No `f_rvalid_o`; `f_rdata_o` keeps its old value.
  - A following F request completes normally.
- Guard build, STARVE_MAX=4, D and F requesting continuously:
  - Grant order D,D,D,D,F,D,D,D,D,F.
  - Without the macro: D only.
- `reset_i` low during WAIT:
  - `m_en_o`, `busy_o` and `rvalid_o` read 0 immediately and stay 0.
  - After release, a new F request completes with cycle-3 latency.
